wishbone_master_bridge: RTL and testbench

WISHBONE_MASTER_BRIDGE -- requirements
Module: wishbone_master_bridge

---
 rtl/wishbone_master_bridge_if.sv | 36 +++
 rtl/wishbone_master_bridge.sv | 118 +++++++++++
 tb/tb_wishbone_master_bridge.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_master_bridge_if.sv
// Host command/response channel plus Wishbone master lanes of the bridge.
// The master modport is the bridge's view; slave is the view of whatever drives it.
interface wishbone_master_bridge_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_wr;
   logic [31:0] cmd_adr;
   logic [31:0] cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        m_we_o;
   logic        m_stb_o;
   logic        m_cyc_o;
   logic [3:0]  m_sel_o;
   logic [31:0] m_adr_o;
   logic [31:0] m_dat_o;
   logic [31:0] m_dat_i;
   logic        m_ack_i;
   logic        m_int_i;
   logic        int_pulse;

   modport master (
      input  cmd_valid, cmd_wr, cmd_adr, cmd_dat, cmd_sel, rsp_ready, m_dat_i, m_ack_i, m_int_i,
      output cmd_ready, rsp_valid, rsp_dat, rsp_err, m_we_o, m_stb_o, m_cyc_o, m_sel_o, m_adr_o,
             m_dat_o, int_pulse
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_adr, cmd_dat, cmd_sel, rsp_ready, m_dat_i, m_ack_i, m_int_i,
      input  cmd_ready, rsp_valid, rsp_dat, rsp_err, m_we_o, m_stb_o, m_cyc_o, m_sel_o, m_adr_o,
             m_dat_o, int_pulse
   );
endinterface

// File: rtl/wishbone_master_bridge.sv
// Single-beat Wishbone master bridge: accepts one host command, runs one bus
// cycle with an ack timeout, then holds the response until the host takes it.
// Also edge-detects the combined slave interrupt.
module wishbone_master_bridge #(
   parameter logic [15:0] TIMEOUT = 16'd1000
) (
   input  logic                    clk,
   input  logic                    rst,
   wishbone_master_bridge_if.master bus
);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   // Wait count at which a still-unacked cycle is abandoned.
   localparam logic [15:0] LastWait = TIMEOUT - 16'd1;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        we_q, we_d;
   logic        stb_q, stb_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] rsp_dat_q, rsp_dat_d;
   logic        rsp_err_q, rsp_err_d;
   logic        int_q;

   // Next-state and lane updates for the idle/bus/response sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      stb_d     = stb_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               state_d = StBus;
               cnt_d   = 16'd0;
               we_d    = bus.cmd_wr;
               adr_d   = bus.cmd_adr;
               dat_d   = bus.cmd_dat;
               sel_d   = bus.cmd_sel;
               stb_d   = 1'b1;
            end
         end
         StBus: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (bus.m_ack_i) begin
               state_d   = StResp;
               stb_d     = 1'b0;
               we_d      = 1'b0;
               rsp_dat_d = we_q ? 32'd0 : bus.m_dat_i;
               rsp_err_d = 1'b0;
            end else if (cnt_q == LastWait) begin
               state_d   = StResp;
               stb_d     = 1'b0;
               we_d      = 1'b0;
               rsp_dat_d = 32'd0;
               rsp_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, bus lanes, response and interrupt history, all cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= 16'd0;
         we_q      <= 1'b0;
         stb_q     <= 1'b0;
         sel_q     <= 4'd0;
         adr_q     <= 32'd0;
         dat_q     <= 32'd0;
         rsp_dat_q <= 32'd0;
         rsp_err_q <= 1'b0;
         int_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         stb_q     <= stb_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
         int_q     <= bus.m_int_i;
      end
   end

   assign bus.cmd_ready = (state_q == StIdle);
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_dat   = rsp_dat_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.m_we_o    = we_q;
   assign bus.m_stb_o   = stb_q;
   assign bus.m_cyc_o   = stb_q;
   assign bus.m_sel_o   = sel_q;
   assign bus.m_adr_o   = adr_q;
   assign bus.m_dat_o   = dat_q;
   // Gated by reset so the pulse is held low while reset is asserted.
   assign bus.int_pulse = rst & bus.m_int_i & ~int_q;

endmodule

// File: tb/tb_wishbone_master_bridge.sv
// Bench for wishbone_master_bridge: transaction-level schedule model with a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_wishbone_master_bridge;

   localparam int Tmo = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wishbone_master_bridge_if bus_if ();

   wishbone_master_bridge #(.TIMEOUT(16'd4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Expected outputs for the current cycle, set by the stimulus schedule.
   logic        chk_on = 1'b0;
   logic        chk_ready, chk_lanes, chk_rsp;
   logic        exp_ready, exp_stb, exp_we, exp_rv, exp_err;
   logic [31:0] exp_adr, exp_dat, exp_rdat;
   logic [3:0]  exp_sel;
   logic        int_rand;
   logic        int_prev;

   int          stb_total = 0;
   int          rsp_total = 0;
   int          int_total = 0;
   logic [31:0] seen_rdat = 32'd0;
   logic        seen_err  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Interrupt history as seen at each clock edge.
   always @(posedge clk or negedge rst) begin
      if (!rst) int_prev <= 1'b0;
      else      int_prev <= bus_if.m_int_i;
   end

   // Compare process, sampling mid-cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("int_pulse", 32'(bus_if.int_pulse), 32'(rst & bus_if.m_int_i & ~int_prev));
         chk("m_cyc_o", 32'(bus_if.m_cyc_o), 32'(exp_stb));
         chk("m_stb_o", 32'(bus_if.m_stb_o), 32'(exp_stb));
         chk("m_we_o", 32'(bus_if.m_we_o), 32'(exp_we));
         chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(exp_rv));
         if (chk_ready) chk("cmd_ready", 32'(bus_if.cmd_ready), 32'(exp_ready));
         if (chk_lanes) begin
            chk("m_adr_o", bus_if.m_adr_o, exp_adr);
            chk("m_dat_o", bus_if.m_dat_o, exp_dat);
            chk("m_sel_o", 32'(bus_if.m_sel_o), 32'(exp_sel));
         end
         if (chk_rsp) begin
            chk("rsp_dat", bus_if.rsp_dat, exp_rdat);
            chk("rsp_err", 32'(bus_if.rsp_err), 32'(exp_err));
         end
      end
      if (bus_if.m_stb_o) stb_total++;
      if (bus_if.int_pulse) int_total++;
      if (bus_if.rsp_valid) begin
         rsp_total++;
         seen_rdat = bus_if.rsp_dat;
         seen_err  = bus_if.rsp_err;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic rdy, input logic stb, input logic we, input logic rv);
      exp_ready = rdy;
      exp_stb   = stb;
      exp_we    = we;
      exp_rv    = rv;
      chk_ready = 1'b1;
      chk_lanes = 1'b0;
      chk_rsp   = 1'b0;
      if (int_rand && ($urandom_range(0, 3) == 0)) bus_if.m_int_i = ~bus_if.m_int_i;
   endtask

   task automatic idle_cycle(input bit noise);
      bus_if.cmd_valid = 1'b0;
      bus_if.m_ack_i   = noise ? 1'($urandom) : 1'b0;
      bus_if.rsp_ready = noise ? 1'($urandom) : 1'b0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      step();
   endtask

   // One transaction; ack_at is the 0-based stb cycle carrying ack (>= Tmo: none).
   task automatic run_txn(input logic wr, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                          input int wait_n, input bit noise);
      bit          err;
      int          nstb;
      logic [31:0] rsp;
      err  = (ack_at >= Tmo);
      nstb = err ? Tmo : ack_at + 1;
      rsp  = (err || wr) ? 32'd0 : rdata;

      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_wr    = wr;
      bus_if.cmd_adr   = adr;
      bus_if.cmd_dat   = dat;
      bus_if.cmd_sel   = sel;
      bus_if.rsp_ready = noise ? 1'($urandom) : 1'b0;
      bus_if.m_ack_i   = noise ? 1'($urandom) : 1'b0;
      bus_if.m_dat_i   = $urandom;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      step();

      for (int i = 0; i < nstb; i++) begin
         bus_if.cmd_valid = noise ? 1'($urandom) : 1'b0;
         if (noise) begin
            bus_if.cmd_wr  = 1'($urandom);
            bus_if.cmd_adr = $urandom;
            bus_if.cmd_dat = $urandom;
            bus_if.cmd_sel = 4'($urandom);
         end
         bus_if.m_ack_i = (i == ack_at);
         bus_if.m_dat_i = (i == ack_at) ? rdata : $urandom;
         bus_if.rsp_ready = noise ? 1'($urandom) : 1'b0;
         set_exp(1'b0, 1'b1, wr, 1'b0);
         chk_lanes = 1'b1;
         exp_adr   = adr;
         exp_dat   = dat;
         exp_sel   = sel;
         step();
      end

      for (int i = 0; i <= wait_n; i++) begin
         bus_if.cmd_valid = noise ? 1'($urandom) : 1'b0;
         bus_if.m_ack_i   = noise ? 1'($urandom) : 1'b0;
         bus_if.m_dat_i   = $urandom;
         bus_if.rsp_ready = (i == wait_n);
         set_exp(1'b0, 1'b0, 1'b0, 1'b1);
         chk_rsp  = 1'b1;
         exp_rdat = rsp;
         exp_err  = err;
         step();
      end
      bus_if.cmd_valid = 1'b0;
      bus_if.m_ack_i   = 1'b0;
      bus_if.rsp_ready = 1'b0;
   endtask

   initial begin
      int s0;
      int r0;
      rst              = 1'b0;
      int_rand         = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_wr    = 1'b0;
      bus_if.cmd_adr   = 32'd0;
      bus_if.cmd_dat   = 32'd0;
      bus_if.cmd_sel   = 4'd0;
      bus_if.rsp_ready = 1'b0;
      bus_if.m_dat_i   = 32'd0;
      bus_if.m_ack_i   = 1'b0;
      bus_if.m_int_i   = 1'b0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);

      #3;
      chk("reset_stb", 32'(bus_if.m_stb_o), 32'd0);
      chk("reset_we", 32'(bus_if.m_we_o), 32'd0);
      chk("reset_adr", bus_if.m_adr_o, 32'd0);
      chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("reset_rsp_dat", bus_if.rsp_dat, 32'd0);
      chk("reset_rsp_err", 32'(bus_if.rsp_err), 32'd0);
      chk("reset_int_pulse", 32'(bus_if.int_pulse), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b1;
      chk_on = 1'b1;
      idle_cycle(1'b0);

      // Write, slave acks in the 2nd stb cycle.
      s0 = stb_total;
      run_txn(1'b1, 32'h0100_0004, 32'hDEADBEEF, 4'hF, 1, 32'hFFFF_FFFF, 0, 1'b0);
      chk("wr_stb_cycles", 32'(stb_total - s0), 32'd2);
      chk("wr_rsp_dat", seen_rdat, 32'd0);
      chk("wr_rsp_err", 32'(seen_err), 32'd0);

      // Read, ack in the 1st stb cycle; issued back to back.
      s0 = stb_total;
      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 32'h12345678, 0, 1'b0);
      chk("rd_stb_cycles", 32'(stb_total - s0), 32'd1);
      chk("rd_rsp_dat", seen_rdat, 32'h12345678);

      // No ack at all: abort after Tmo stb cycles.
      s0 = stb_total;
      run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h3, Tmo + 1, 32'hCAFEF00D, 0, 1'b0);
      chk("to_stb_cycles", 32'(stb_total - s0), 32'd4);
      chk("to_rsp_err", 32'(seen_err), 32'd1);
      chk("to_rsp_dat", seen_rdat, 32'd0);

      // Ack lands on the timeout cycle and wins.
      s0 = stb_total;
      run_txn(1'b0, 32'h0000_0030, 32'h0, 4'h1, Tmo - 1, 32'hA5A5_5A5A, 0, 1'b0);
      chk("tie_stb_cycles", 32'(stb_total - s0), 32'd4);
      chk("tie_rsp_err", 32'(seen_err), 32'd0);
      chk("tie_rsp_dat", seen_rdat, 32'hA5A5_5A5A);

      // Response backpressure for 10 cycles.
      r0 = rsp_total;
      run_txn(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 10, 1'b0);
      chk("bp_rsp_cycles", 32'(rsp_total - r0), 32'd11);
      chk("bp_rsp_dat", seen_rdat, 32'h0BAD_F00D);
      idle_cycle(1'b0);

      // Reset in the middle of a bus cycle, then an interrupt edge.
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_wr    = 1'b1;
      bus_if.cmd_adr   = 32'h0000_0050;
      bus_if.cmd_dat   = 32'h1111_2222;
      bus_if.cmd_sel   = 4'hC;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      bus_if.cmd_valid = 1'b0;
      set_exp(1'b0, 1'b1, 1'b1, 1'b0);
      chk_lanes = 1'b1;
      exp_adr   = 32'h0000_0050;
      exp_dat   = 32'h1111_2222;
      exp_sel   = 4'hC;
      step();
      chk("pre_rst_stb", 32'(bus_if.m_stb_o), 32'd1);
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ready = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_cyc_now", 32'(bus_if.m_cyc_o), 32'd0);
      chk("rst_stb_now", 32'(bus_if.m_stb_o), 32'd0);
      chk("rst_adr_now", bus_if.m_adr_o, 32'd0);
      repeat (3) begin
         set_exp(1'b0, 1'b0, 1'b0, 1'b0);
         chk_ready = 1'b0;
         step();
      end
      rst = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus_if.cmd_ready), 32'd1);
      set_exp(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      s0 = int_total;
      bus_if.m_int_i = 1'b1;
      repeat (5) idle_cycle(1'b0);
      chk("int_pulse_count", 32'(int_total - s0), 32'd1);
      bus_if.m_int_i = 1'b0;
      idle_cycle(1'b0);

      // Randomized traffic with ignored-input noise.
      int_rand = 1'b1;
      for (int n = 0; n < 80; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) idle_cycle(1'b1);
         run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, Tmo + 1),
                 $urandom, $urandom_range(0, 3), 1'b1);
      end
      idle_cycle(1'b1);
      chk_on = 1'b0;
      @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
